// File: rtl/cnn_cls_pkg.sv
// Shared types, default widths and saturation helpers
// for the sequential learning classifier.
package cnn_cls_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FC1,
        FC2,
        ARG,
        OUT,
        UPD
    } state_e;

    localparam int DEF_INPUT_SIZE     = 20;
    localparam int DEF_HIDDEN_NEURONS = 64;
    localparam int DEF_CLASS_COUNT    = 8;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_WGT_W          = 16;
    localparam int DEF_ACC_W          = 48;
    localparam int DEF_LR_SHIFT       = 2;
    localparam int DEF_ANOMALY_CLASS  = 7;

    // Wide carrier so any configured width can be clamped.
    localparam int SAT_W = 128;

    function automatic logic signed [SAT_W-1:0] sat_gen(
        input logic signed [SAT_W-1:0] v,
        input int                      w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = ~hi;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_acc_to_data(
        input logic signed [SAT_W-1:0] v,
        input int                      data_w
    );
        return sat_gen(v, data_w);
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_wgt(
        input logic signed [SAT_W-1:0] v,
        input int                      wgt_w
    );
        return sat_gen(v, wgt_w);
    endfunction

endpackage

// File: rtl/cnn_classifier_learn_seq_mac.sv
// cnn_mac_sat: signed multiply with saturating accumulate.
// clr restarts the sum; with en it loads the first product.
module cnn_mac_sat
    import cnn_cls_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int WGT_W  = DEF_WGT_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [WGT_W-1:0]  b,
    output logic signed [ACC_W-1:0]  sum_o
);

    localparam int PW = DATA_W + WGT_W;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W:0]   sum_w;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    always_comb begin
        prod  = PW'(a) * PW'(b);
        base  = clr ? '0 : acc_q;
        sum_w = (ACC_W+1)'(base) + (ACC_W+1)'(prod);
        if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
            sum_o = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sum_o = sum_w[ACC_W-1:0];
        end
        acc_d = acc_q;
        if (en) begin
            acc_d = sum_o;
        end else if (clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/cnn_classifier_learn_seq.sv
// Time-multiplexed FC1/FC2/argmax classifier with FC2 perceptron
// learning. `define ANOMALY_LEARN_EN trains anomalies to ANOMALY_CLASS.
module cnn_classifier_learn_seq
    import cnn_cls_pkg::*;
#(
    parameter int INPUT_SIZE     = DEF_INPUT_SIZE,
    parameter int HIDDEN_NEURONS = DEF_HIDDEN_NEURONS,
    parameter int CLASS_COUNT    = DEF_CLASS_COUNT,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int WGT_W          = DEF_WGT_W,
    parameter int ACC_W          = DEF_ACC_W,
    parameter int LR_SHIFT       = DEF_LR_SHIFT,
    parameter int ANOMALY_CLASS  = DEF_ANOMALY_CLASS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INPUT_SIZE*DATA_W-1:0] features_in_flat,
    input  logic [7:0]                   label_in,
    input  logic                         label_in_valid,
    input  logic                         anomaly_flag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   class_label,
    output logic [ACC_W-1:0]             class_score,
    output logic                         update_done,
    output logic                         label_err
);

    localparam int IW  = $clog2(INPUT_SIZE);
    localparam int HW  = $clog2(HIDDEN_NEURONS);
    localparam int CIW = $clog2(CLASS_COUNT);
    // FC1 weights are fixed at +1 in this generation.
    localparam logic signed [WGT_W-1:0] W1 = WGT_W'(1);

    state_e state_q, state_d;

    logic signed [DATA_W-1:0] feat_q  [INPUT_SIZE];
    logic signed [DATA_W-1:0] feat_d  [INPUT_SIZE];
    logic signed [DATA_W-1:0] hid_q   [HIDDEN_NEURONS];
    logic signed [DATA_W-1:0] hid_d   [HIDDEN_NEURONS];
    logic signed [ACC_W-1:0]  score_q [CLASS_COUNT];
    logic signed [ACC_W-1:0]  score_d [CLASS_COUNT];
    logic signed [WGT_W-1:0]  w2_q [CLASS_COUNT][HIDDEN_NEURONS];
    logic signed [WGT_W-1:0]  w2_d [CLASS_COUNT][HIDDEN_NEURONS];

    logic [IW-1:0]           i_q, i_d;
    logic [HW-1:0]           h_q, h_d;
    logic [CIW-1:0]          c_q, c_d;
    logic [CIW-1:0]          tgt_q, tgt_d;
    logic                    tgt_vld_q, tgt_vld_d;
    logic [CIW-1:0]          best_idx_q, best_idx_d;
    logic signed [ACC_W-1:0] best_q, best_d;
    logic                    out_valid_q, out_valid_d;
    logic [CIW-1:0]          cls_q, cls_d;
    logic signed [ACC_W-1:0] cls_score_q, cls_score_d;
    logic                    label_err_q, label_err_d;

    logic                     i_last, h_last, c_last;
    logic                     out_hs, need_upd, lbl_ok;
    logic                     mac_clr, mac_en;
    logic signed [DATA_W-1:0] mac_a;
    logic signed [WGT_W-1:0]  mac_b;
    logic signed [ACC_W-1:0]  mac_sum;
    logic signed [DATA_W-1:0] delta;

    assign i_last   = i_q == IW'(INPUT_SIZE - 1);
    assign h_last   = h_q == HW'(HIDDEN_NEURONS - 1);
    assign c_last   = c_q == CIW'(CLASS_COUNT - 1);
    assign out_hs   = out_valid_q && out_ready;
    assign need_upd = tgt_vld_q && (tgt_q != cls_q);
    assign lbl_ok   = label_in_valid
                   && ({1'b0, label_in} < 9'(CLASS_COUNT));

`ifndef ANOMALY_LEARN_EN
    logic unused_anom;
    assign unused_anom = anomaly_flag ^ (ANOMALY_CLASS != 0);
`endif

    cnn_mac_sat #(
        .DATA_W (DATA_W),
        .WGT_W  (WGT_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (mac_a),
        .b     (mac_b),
        .sum_o (mac_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = FC1;
            FC1:  if (i_last && h_last) state_d = FC2;
            FC2:  if (h_last && c_last) state_d = ARG;
            ARG:  if (c_last) state_d = OUT;
            OUT:  if (out_hs) state_d = need_upd ? UPD : IDLE;
            UPD:  if (h_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = state_q == IDLE;
        update_done = (state_q == UPD) && h_last;
        out_valid   = out_valid_q;
        class_label = 8'(cls_q);
        class_score = cls_score_q;
        label_err   = label_err_q;
    end

    always_comb begin
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        mac_a   = '0;
        mac_b   = '0;
        if (state_q == FC1) begin
            mac_en  = 1'b1;
            mac_clr = i_q == '0;
            mac_a   = feat_q[i_q];
            mac_b   = W1;
        end else if (state_q == FC2) begin
            mac_en  = 1'b1;
            mac_clr = h_q == '0;
            mac_a   = hid_q[h_q];
            mac_b   = w2_q[c_q][h_q];
        end
    end

    always_comb begin
        feat_d      = feat_q;
        hid_d       = hid_q;
        score_d     = score_q;
        w2_d        = w2_q;
        i_d         = i_q;
        h_d         = h_q;
        c_d         = c_q;
        tgt_d       = tgt_q;
        tgt_vld_d   = tgt_vld_q;
        best_idx_d  = best_idx_q;
        best_d      = best_q;
        out_valid_d = out_valid_q;
        cls_d       = cls_q;
        cls_score_d = cls_score_q;
        label_err_d = label_err_q;
        delta       = hid_q[h_q] >>> LR_SHIFT;
        unique case (state_q)
            IDLE: if (in_valid) begin
                for (int k = 0; k < INPUT_SIZE; k++) begin
                    feat_d[k] = features_in_flat[k*DATA_W +: DATA_W];
                end
                tgt_vld_d = lbl_ok;
                tgt_d     = label_in[CIW-1:0];
                if (label_in_valid && !lbl_ok) label_err_d = 1'b1;
`ifdef ANOMALY_LEARN_EN
                if (!label_in_valid && anomaly_flag) begin
                    tgt_vld_d = 1'b1;
                    tgt_d     = CIW'(ANOMALY_CLASS);
                end
`endif
                i_d = '0;
                h_d = '0;
                c_d = '0;
            end
            FC1: begin
                i_d = i_last ? '0 : i_q + IW'(1);
                if (i_last) begin
                    hid_d[h_q] = mac_sum[ACC_W-1] ? '0 : DATA_W'(
                        sat_acc_to_data(SAT_W'(mac_sum), DATA_W));
                    h_d = h_last ? '0 : h_q + HW'(1);
                end
            end
            FC2: begin
                h_d = h_last ? '0 : h_q + HW'(1);
                if (h_last) begin
                    score_d[c_q] = mac_sum;
                    c_d = c_last ? '0 : c_q + CIW'(1);
                end
            end
            ARG: begin
                // Strict compare keeps the lowest index on ties.
                if (c_q == '0 || score_q[c_q] > best_q) begin
                    best_d     = score_q[c_q];
                    best_idx_d = c_q;
                end
                c_d = c_last ? '0 : c_q + CIW'(1);
            end
            OUT: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    cls_d       = best_idx_q;
                    cls_score_d = best_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    h_d         = '0;
                end
            end
            UPD: begin
                w2_d[tgt_q][h_q] = WGT_W'(sat_wgt(
                    SAT_W'(w2_q[tgt_q][h_q]) + SAT_W'(delta), WGT_W));
                w2_d[cls_q][h_q] = WGT_W'(sat_wgt(
                    SAT_W'(w2_q[cls_q][h_q]) - SAT_W'(delta), WGT_W));
                h_d = h_last ? '0 : h_q + HW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < INPUT_SIZE; k++) feat_q[k] <= '0;
            for (int h = 0; h < HIDDEN_NEURONS; h++) hid_q[h] <= '0;
            for (int c = 0; c < CLASS_COUNT; c++) begin
                score_q[c] <= '0;
                for (int h = 0; h < HIDDEN_NEURONS; h++) begin
                    w2_q[c][h] <= '0;
                end
            end
            i_q         <= '0;
            h_q         <= '0;
            c_q         <= '0;
            tgt_q       <= '0;
            tgt_vld_q   <= 1'b0;
            best_idx_q  <= '0;
            best_q      <= '0;
            out_valid_q <= 1'b0;
            cls_q       <= '0;
            cls_score_q <= '0;
            label_err_q <= 1'b0;
        end else begin
            feat_q      <= feat_d;
            hid_q       <= hid_d;
            score_q     <= score_d;
            w2_q        <= w2_d;
            i_q         <= i_d;
            h_q         <= h_d;
            c_q         <= c_d;
            tgt_q       <= tgt_d;
            tgt_vld_q   <= tgt_vld_d;
            best_idx_q  <= best_idx_d;
            best_q      <= best_d;
            out_valid_q <= out_valid_d;
            cls_q       <= cls_d;
            cls_score_q <= cls_score_d;
            label_err_q <= label_err_d;
        end
    end

endmodule

// File: tb/tb_cnn_classifier_learn_seq.sv
// Randomised bench for cnn_classifier_learn_seq against an
// arithmetic reference model of the classifier and its learning rule.
module tb_cnn_classifier_learn_seq;

    localparam int IS  = 20;
    localparam int HN  = 64;
    localparam int CC  = 8;
    localparam int DW  = 32;
    localparam int AW  = 48;
    localparam int LAT = HN*IS + CC*HN + CC + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [IS*DW-1:0]  features_in_flat;
    logic [7:0]        label_in;
    logic              label_in_valid;
    logic              anomaly_flag;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        class_label;
    logic [AW-1:0]     class_score;
    logic              update_done;
    logic              label_err;

    always #5 clk = ~clk;

    cnn_classifier_learn_seq dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .features_in_flat (features_in_flat),
        .label_in         (label_in),
        .label_in_valid   (label_in_valid),
        .anomaly_flag     (anomaly_flag),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .class_label      (class_label),
        .class_score      (class_score),
        .update_done      (update_done),
        .label_err        (label_err)
    );

    typedef struct {
        int            lat;
        int            lbl;
        logic [AW-1:0] score;
        bit            stable;
        bit            ir_low;
        bit            ov_drop;
        int            pulses;
        int            idle_wait;
    } obs_t;

    int     n_vec = 0;
    int     n_bad = 0;
    longint w2m [CC][HN];
    bit     err_m;
    int     f [IS];

    function automatic longint clamp(longint v, int w);
        longint hi;
        hi = (longint'(1) <<< (w - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < CC; c++)
            for (int h = 0; h < HN; h++) w2m[c][h] = 0;
        err_m = 0;
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < IS; i++) f[i] = v;
    endtask

    // Reference: w1 is all ones, so every hidden unit is ReLU(sum x).
    task automatic model_run(input int lbl, input bit lv, input bit an,
                             output int el, output longint es,
                             output bit eu);
        longint hid, acc, d;
        longint sc [CC];
        int     t;
        bit     tv;
        hid = 0;
        for (int i = 0; i < IS; i++) hid += f[i];
        hid = clamp(hid, DW);
        if (hid < 0) hid = 0;
        for (int c = 0; c < CC; c++) begin
            acc = 0;
            for (int h = 0; h < HN; h++)
                acc = clamp(acc + w2m[c][h] * hid, AW);
            sc[c] = acc;
        end
        el = 0;
        es = sc[0];
        for (int c = 1; c < CC; c++)
            if (sc[c] > es) begin
                es = sc[c];
                el = c;
            end
        tv = 0;
        t  = 0;
        if (lv) begin
            if (lbl < CC) begin
                tv = 1;
                t  = lbl;
            end else begin
                err_m = 1;
            end
        end
`ifdef ANOMALY_LEARN_EN
        else if (an) begin
            tv = 1;
            t  = 7;
        end
`endif
        eu = tv && (t != el);
        if (eu) begin
            d = hid >>> 2;
            for (int h = 0; h < HN; h++) begin
                w2m[t][h]  = clamp(w2m[t][h] + d, 16);
                w2m[el][h] = clamp(w2m[el][h] - d, 16);
            end
        end
    endtask

    task automatic run_vec(input int lbl, input bit lv, input bit an,
                           input int hold, input bit poke,
                           output obs_t o);
        int k;
        o = '{default: 0};
        @(posedge clk);
        #1;
        k = 0;
        while (!in_ready && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        for (int i = 0; i < IS; i++) features_in_flat[i*DW +: DW] = f[i];
        label_in       = 8'(lbl);
        label_in_valid = lv;
        anomaly_flag   = an;
        in_valid       = 1'b1;
        @(posedge clk);
        #1;
        in_valid = poke;
        if (poke) begin
            features_in_flat = ~features_in_flat;
            label_in         = 8'd2;
            label_in_valid   = 1'b1;
            anomaly_flag     = 1'b1;
        end
        o.ir_low = 1;
        while (!out_valid && o.lat < 3000) begin
            if (o.lat == 50) in_valid = 1'b0;
            if (in_ready) o.ir_low = 0;
            @(posedge clk);
            #1;
            o.lat++;
        end
        in_valid       = 1'b0;
        label_in_valid = 1'b0;
        anomaly_flag   = 1'b0;
        n_vec++;
        if (!out_valid) begin
            n_bad++;
            $display("FAIL out_valid_timeout: got none within %0d, want %0d",
                     o.lat, LAT);
            return;
        end
        if (in_ready) o.ir_low = 0;
        o.lbl    = class_label;
        o.score  = class_score;
        o.stable = 1;
        repeat (hold) begin
            @(posedge clk);
            #1;
            if (!out_valid || class_label !== 8'(o.lbl)
                || class_score !== o.score) o.stable = 0;
            if (in_ready) o.ir_low = 0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        o.ov_drop = !out_valid;
        o.pulses  = update_done;
        while (!in_ready && o.idle_wait < 300) begin
            @(posedge clk);
            #1;
            o.idle_wait++;
            if (update_done) o.pulses++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec += 6;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready);
        end
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid);
        end
        if (class_label !== 8'd0) begin
            n_bad++; $display("FAIL rst_label: got %0d want 0", class_label);
        end
        if (class_score !== '0) begin
            n_bad++; $display("FAIL rst_score: got %0d want 0", class_score);
        end
        if (update_done !== 1'b0) begin
            n_bad++; $display("FAIL rst_upd: got %b want 0", update_done);
        end
        if (label_err !== 1'b0) begin
            n_bad++; $display("FAIL rst_lerr: got %b want 0", label_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_all_ones();
        obs_t o; int el; longint es; bit eu;
        fill(1);
        model_run(0, 0, 0, el, es, eu);
        run_vec(0, 0, 0, 0, 0, o);
        n_vec += 5;
        if (o.lat !== LAT) begin
            n_bad++; $display("FAIL ones_latency: got %0d want %0d", o.lat, LAT);
        end
        if (o.lbl !== el) begin
            n_bad++; $display("FAIL ones_label: got %0d want %0d", o.lbl, el);
        end
        if (o.score !== AW'(es)) begin
            n_bad++; $display("FAIL ones_score: got %0d want %0d", o.score, es);
        end
        if (o.ov_drop !== 1'b1) begin
            n_bad++; $display("FAIL ones_ov_drop: got %b want 1", o.ov_drop);
        end
        if (o.pulses !== 0) begin
            n_bad++; $display("FAIL ones_pulses: got %0d want 0", o.pulses);
        end
    endtask

    task automatic test_train();
        obs_t o; int el; longint es; bit eu;
        fill(1);
        model_run(3, 1, 0, el, es, eu);
        run_vec(3, 1, 0, 0, 0, o);
        n_vec += 3;
        if (o.lbl !== 0) begin
            n_bad++; $display("FAIL train_label: got %0d want 0", o.lbl);
        end
        if (o.pulses !== 1) begin
            n_bad++; $display("FAIL train_pulses: got %0d want 1", o.pulses);
        end
        if (o.idle_wait !== HN) begin
            n_bad++; $display("FAIL train_upd_len: got %0d want %0d",
                              o.idle_wait, HN);
        end
        model_run(0, 0, 0, el, es, eu);
        run_vec(0, 0, 0, 0, 0, o);
        n_vec += 2;
        if (o.lbl !== 3 || el !== 3) begin
            n_bad++; $display("FAIL trained_label: got %0d want 3", o.lbl);
        end
        if (o.score !== AW'(es) || es !== 6400) begin
            n_bad++; $display("FAIL trained_score: got %0d want 6400", o.score);
        end
    endtask

    task automatic test_label_eq_pred();
        obs_t o; int el; longint es; bit eu;
        fill(1);
        model_run(3, 1, 0, el, es, eu);
        run_vec(3, 1, 0, 0, 0, o);
        n_vec += 3;
        if (o.lbl !== el) begin
            n_bad++; $display("FAIL eq_label: got %0d want %0d", o.lbl, el);
        end
        if (o.pulses !== 0) begin
            n_bad++; $display("FAIL eq_pulses: got %0d want 0", o.pulses);
        end
        if (o.idle_wait !== 0) begin
            n_bad++; $display("FAIL eq_idle: got %0d want 0", o.idle_wait);
        end
    endtask

    task automatic test_bad_label();
        obs_t o; int el; longint es; bit eu;
        fill(1);
        model_run(8, 1, 0, el, es, eu);
        run_vec(8, 1, 0, 0, 0, o);
        n_vec += 2;
        if (label_err !== 1'b1) begin
            n_bad++; $display("FAIL bad_lerr: got %b want 1", label_err);
        end
        if (o.pulses !== 0) begin
            n_bad++; $display("FAIL bad_pulses: got %0d want 0", o.pulses);
        end
        model_run(0, 0, 0, el, es, eu);
        run_vec(0, 0, 0, 0, 0, o);
        n_vec++;
        if (o.score !== AW'(es) || o.lbl !== el) begin
            n_bad++; $display("FAIL bad_weights: got %0d/%0d want %0d/%0d",
                              o.lbl, o.score, el, es);
        end
    endtask

    task automatic test_zero_neg();
        obs_t o; int el; longint es; bit eu;
        for (int m = 0; m < 2; m++) begin
            fill(m == 0 ? -1 : 0);
            model_run(0, 0, 0, el, es, eu);
            run_vec(0, 0, 0, 0, 0, o);
            n_vec += 2;
            if (o.lbl !== el) begin
                n_bad++; $display("FAIL zn_label: got %0d want %0d", o.lbl, el);
            end
            if (o.score !== AW'(es)) begin
                n_bad++; $display("FAIL zn_score: got %0d want %0d", o.score, es);
            end
        end
    endtask

    task automatic test_sat();
        obs_t o; int el; longint es; bit eu;
        int lbls [3] = '{0, 5, 0};
        bit lvs  [3] = '{0, 1, 0};
        fill(32'h7FFF_FFFF);
        for (int s = 0; s < 3; s++) begin
            model_run(lbls[s], lvs[s], 0, el, es, eu);
            run_vec(lbls[s], lvs[s], 0, 0, 0, o);
            n_vec += 3;
            if (o.lbl !== el) begin
                n_bad++; $display("FAIL sat_label: got %0d want %0d", o.lbl, el);
            end
            if (o.score !== AW'(es)) begin
                n_bad++; $display("FAIL sat_score: got %0d want %0d", o.score, es);
            end
            if (o.pulses !== int'(eu)) begin
                n_bad++; $display("FAIL sat_pulses: got %0d want %0d",
                                  o.pulses, eu);
            end
        end
    endtask

    task automatic test_backpressure();
        obs_t o; int el; longint es; bit eu;
        for (int i = 0; i < IS; i++) f[i] = $urandom_range(0, 2000) - 1000;
        model_run(0, 0, 0, el, es, eu);
        run_vec(0, 0, 0, 100, 1, o);
        n_vec += 4;
        if (o.stable !== 1'b1) begin
            n_bad++; $display("FAIL bp_stable: got %b want 1", o.stable);
        end
        if (o.ir_low !== 1'b1) begin
            n_bad++; $display("FAIL bp_in_ready_low: got %b want 1", o.ir_low);
        end
        if (o.lbl !== el) begin
            n_bad++; $display("FAIL bp_label: got %0d want %0d", o.lbl, el);
        end
        if (o.score !== AW'(es)) begin
            n_bad++; $display("FAIL bp_score: got %0d want %0d", o.score, es);
        end
    endtask

    task automatic test_random();
        obs_t o; int el; longint es; bit eu;
        int lbl; bit lv, an; int mode;
        for (int r = 0; r < 6; r++) begin
            mode = $urandom_range(0, 2);
            for (int i = 0; i < IS; i++) begin
                if (mode == 0) f[i] = $urandom_range(0, 200) - 100;
                else if (mode == 1) f[i] = $urandom;
                else f[i] = $urandom_range(0, 1 << 24);
            end
            lbl = $urandom_range(0, 9);
            lv  = $urandom_range(0, 1);
            an  = $urandom_range(0, 1);
            model_run(lbl, lv, an, el, es, eu);
            run_vec(lbl, lv, an, $urandom_range(0, 3), 0, o);
            n_vec += 5;
            if (o.lbl !== el) begin
                n_bad++; $display("FAIL rnd%0d_label: got %0d want %0d",
                                  r, o.lbl, el);
            end
            if (o.score !== AW'(es)) begin
                n_bad++; $display("FAIL rnd%0d_score: got %0d want %0d",
                                  r, o.score, es);
            end
            if (o.pulses !== int'(eu)) begin
                n_bad++; $display("FAIL rnd%0d_pulses: got %0d want %0d",
                                  r, o.pulses, eu);
            end
            if (o.idle_wait !== (eu ? HN : 0)) begin
                n_bad++; $display("FAIL rnd%0d_idle: got %0d want %0d",
                                  r, o.idle_wait, eu ? HN : 0);
            end
            if (label_err !== err_m) begin
                n_bad++; $display("FAIL rnd%0d_lerr: got %b want %b",
                                  r, label_err, err_m);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o; int el; longint es; bit eu;
        fill(1);
        @(posedge clk);
        #1;
        for (int i = 0; i < IS; i++) features_in_flat[i*DW +: DW] = f[i];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_vec += 3;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL mid_in_ready: got %b want 1", in_ready);
        end
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL mid_out_valid: got %b want 0", out_valid);
        end
        if (label_err !== 1'b0) begin
            n_bad++; $display("FAIL mid_lerr: got %b want 0", label_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        model_run(0, 0, 0, el, es, eu);
        run_vec(0, 0, 0, 0, 0, o);
        n_vec += 2;
        if (o.lbl !== el || el !== 0) begin
            n_bad++; $display("FAIL mid_label: got %0d want 0", o.lbl);
        end
        if (o.score !== AW'(es) || es !== 0) begin
            n_bad++; $display("FAIL mid_score: got %0d want 0", o.score);
        end
    endtask

    task automatic test_anomaly();
        obs_t o; int el; longint es; bit eu;
        fill(1);
        model_run(0, 0, 1, el, es, eu);
        run_vec(0, 0, 1, 0, 0, o);
        n_vec++;
        if (o.pulses !== int'(eu)) begin
            n_bad++; $display("FAIL anom_pulses: got %0d want %0d", o.pulses, eu);
        end
        model_run(0, 0, 0, el, es, eu);
        run_vec(0, 0, 0, 0, 0, o);
        n_vec += 2;
        if (o.lbl !== el) begin
            n_bad++; $display("FAIL anom_label: got %0d want %0d", o.lbl, el);
        end
        if (o.score !== AW'(es)) begin
            n_bad++; $display("FAIL anom_score: got %0d want %0d", o.score, es);
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        in_valid         = 1'b0;
        features_in_flat = '0;
        label_in         = '0;
        label_in_valid   = 1'b0;
        anomaly_flag     = 1'b0;
        out_ready        = 1'b0;
        test_reset();
        test_all_ones();
        test_train();
        test_label_eq_pred();
        test_bad_label();
        test_zero_neg();
        test_sat();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_anomaly();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cnn_classifier_learn_seq.md
Name: cnn_classifier_learn_seq

Overview:
Parametrised, time-multiplexed successor of the FC1/FC2 learning classifier. One saturating MAC runs FC1 (ReLU), then FC2, then argmax, using a feature vector accepted on a valid/ready handshake. When a label accompanies the vector and the prediction is wrong, the block applies an on-chip perceptron update to the FC2 weights. It sits after the feature extractor and drives class labels to the host/anomaly logic.

Parameters:
INPUT_SIZE, 20, number of input features
HIDDEN_NEURONS, 64, FC1 outputs
CLASS_COUNT, 8, FC2 outputs (2..256)
DATA_W, 32, signed feature / hidden width
WGT_W, 16, signed weight width
ACC_W, 48, signed accumulator / score width
LR_SHIFT, 2, learning rate as arithmetic right shift
ANOMALY_CLASS, 7, training target for anomalies (only with ANOMALY_LEARN_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  feature vector valid
in_ready  out  1  block idle, can accept a vector
features_in_flat  in  INPUT_SIZE*DATA_W  feature i at [i*DATA_W +: DATA_W], signed
label_in  in  8  training label, sampled on accept
label_in_valid  in  1  label present, sampled on accept
anomaly_flag  in  1  anomaly marker, sampled on accept
out_valid  out  1  result valid, held until out_ready
out_ready  in  1  result consumed
class_label  out  8  argmax class
class_score  out  ACC_W  winning score
update_done  out  1  one-cycle pulse when a weight update completes
label_err  out  1  sticky: a label >= CLASS_COUNT was received

Behaviour:
- Async reset (rst_n=0): FSM to IDLE; in_ready=1; out_valid=0, class_label=0, class_score=0, update_done=0, label_err=0. All fc1 weights set to +1, all fc2 weights to 0. Reset mid-operation aborts the current vector without producing output.
- Accept occurs when in_valid & in_ready at a clock edge. Features, label_in, label_in_valid and anomaly_flag are latched. in_ready drops the next cycle.
- FSM states: IDLE -> FC1 -> FC2 -> ARG -> OUT -> (UPD) -> IDLE.
- FC1: HIDDEN_NEURONS*INPUT_SIZE cycles, one MAC per cycle. hidden[h] = ReLU(sum_i w1[h][i]*x[i]), saturated to DATA_W.
- FC2: CLASS_COUNT*HIDDEN_NEURONS cycles. score[c] = sum_h w2[c][h]*hidden[h].
- ARG: CLASS_COUNT cycles. Uses strict greater-than, so ties resolve to the lowest index.
- Latency: out_valid rises at edge accept+HIDDEN_NEURONS*INPUT_SIZE+CLASS_COUNT*HIDDEN_NEURONS+CLASS_COUNT+1.
- OUT: out_valid, class_label and class_score are held stable until out_ready=1. out_valid deasserts on the edge after the handshake.
- Accumulation: products are DATA_W+WGT_W signed, sign-extended to ACC_W. Accumulation saturates at the ACC_W limits and never wraps.
- Training target t: label_in when label_in_valid=1 and label_in < CLASS_COUNT. A label >= CLASS_COUNT sets label_err and no update is made.
- UPD is entered after the output handshake only when t exists and t != class_label. It takes HIDDEN_NEURONS cycles.
  - Per h: w2[t][h] += hidden[h]>>>LR_SHIFT and w2[p][h] -= hidden[h]>>>LR_SHIFT, where p = class_label.
  - Both updates saturate at WGT_W.
  - update_done pulses in the last UPD cycle, then the FSM returns to IDLE.
- If t == p, no update is made and there is no update_done pulse.
- FC1 weights are not trained in this generation.

Optional Feature:
ANOMALY_LEARN_EN:
- Defined: when label_in_valid=0 and latched anomaly_flag=1, t = ANOMALY_CLASS. A valid label takes priority over the anomaly flag.
- Undefined: anomaly_flag is ignored (port retained, unused).

Decomposition:
- Package cnn_cls_pkg holds:
  - state enum (IDLE, FC1, FC2, ARG, OUT, UPD);
  - default width constants;
  - saturate-to-width functions for ACC_W→DATA_W and for WGT_W.
- One sub-module, cnn_mac_sat: signed multiply plus saturating accumulate, with a clear input and an enable input.

Test Plan:
- Reset, all features 1 -> hidden=20 each; all scores 0; class_label=0, class_score=0; out_valid at accept+1801 cycles (defaults).
- Same vector with label_in=3, label_in_valid=1 -> class 0 reported; UPD runs 64 cycles; update_done pulses once; w2[3][h]=5, w2[0][h]=-5. Rerun without label -> class_label=3, class_score=6400.
- Label equal to prediction (label 3 on the rerun) -> no update_done; weights unchanged. label_in=8 -> label_err=1; no update.
- All features -1 or all 0 -> hidden=0 -> class_label=0, score 0. Features 0x7FFFFFFF -> saturating accumulation, no wrap.
- out_ready held low 100 cycles -> out_valid, class_label and class_score stable; in_ready=0 throughout. in_valid during FC1 is not accepted.
- rst_n low mid-FC1 after training -> in_ready=1 and out_valid=0 immediately; weights restored. Next all-ones vector -> class 0. With ANOMALY_LEARN_EN, anomaly_flag=1 and no label -> w2[7][h]=5, next result class 7.
